uart_tx_engine: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 51 +++++
 rtl/uart_tx_engine.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit path.
//   parity_e   : parity mode selector (none / odd / even)
//   tx_state_e : transmitter FSM states
//   calc_div   : rounded clock-cycles-per-bit divisor
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Nearest-integer divisor: adding half the baud rate rounds the quotient.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..DIV-1 while enabled and pulses out_tick
// for one cycle when the count reaches DIV-1, wrapping back to 0.
//   in_clk     : system clock
//   in_rst_n   : asynchronous active-low reset (counter -> 0)
//   in_restart : synchronous restart, forces the counter to 0
//   in_en      : count enable
//   out_tick   : one-cycle pulse at the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned DIV = 234
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_restart,
    input  logic in_en,
    output logic out_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (in_restart) begin
            cnt_next = '0;
        end else if (in_en) begin
            if (cnt_reg == CNT_MAX) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A restart takes priority so a fresh frame never inherits a stale tick.
    assign out_tick = in_en && !in_restart && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// UART transmitter: frames a byte as start, 8 data bits LSB-first,
// optional parity and 1 or 2 stop bits. All outputs are registered.
//   in_clk   : system clock
//   in_rst_n : asynchronous active-low reset
//   in_data  : byte to send, latched when a request is accepted
//   in_s_en  : send request, accepted only while out_s_bs is low
//   out_s_bs : busy, high for the whole frame
//   out_s_rd : one-cycle pulse when the frame has completed
//   out_tx   : serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 27_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [7:0] in_data,
    input  logic       in_s_en,
    output logic       out_s_bs,
    output logic       out_s_rd,
    output logic       out_tx
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_ODD :
                                   ((PARITY == 2) ? PAR_EVEN : PAR_NONE);
    localparam bit HAS_PARITY = (PAR_MODE != PAR_NONE);
    // Value of the 1-bit stop counter during the last stop bit.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "uart_tx_engine: clock-to-baud divisor must be at least 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_engine: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $fatal(1, "uart_tx_engine: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       stop_cnt_reg, stop_cnt_next;
    logic       parity_reg, parity_next;
    logic       tx_reg, tx_next;
    logic       bs_reg, bs_next;
    logic       rd_reg, rd_next;

    logic       accept;
    logic       tick;

    assign accept = in_s_en && !bs_reg;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_restart (accept),
        .in_en      (bs_reg),
        .out_tick   (tick)
    );

    // Next-state logic also computes the next value of each registered
    // output, so out_tx changes only on clock edges.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        tx_next       = tx_reg;
        bs_next       = bs_reg;
        rd_next       = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                if (accept) begin
                    state_next    = TX_START;
                    shift_next    = in_data;
                    parity_next   = (PAR_MODE == PAR_ODD) ? ~^in_data : ^in_data;
                    bit_idx_next  = 3'd0;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b0;
                    bs_next       = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_next = TX_DATA;
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_idx_reg == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_next = TX_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = TX_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // shift_reg[0] already holds the next data bit.
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_next = TX_STOP;
                    tx_next    = 1'b1;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        state_next = TX_IDLE;
                        bs_next    = 1'b0;
                        rd_next    = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                tx_next    = 1'b1;
                bs_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_reg    <= TX_IDLE;
            shift_reg    <= 8'h00;
            bit_idx_reg  <= 3'd0;
            stop_cnt_reg <= 1'b0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            bs_reg       <= 1'b0;
            rd_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            bs_reg       <= bs_next;
            rd_reg       <= rd_next;
        end
    end

    assign out_tx   = tx_reg;
    assign out_s_bs = bs_reg;
    assign out_s_rd = rd_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine. Five instances cover the parameter
// sets: 0 = no parity/1 stop, 1 = even/1 stop, 2 = odd/1 stop,
// 3 = even/2 stop (all DIV = 10), 4 = default 27 MHz / 115200 (DIV = 234).
// Each transaction records the selected instance's line cycle by cycle
// (sample index 0 = first start-bit cycle) and checks the recorded frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic [4:0] s_en = 5'b00000;
    logic [4:0] tx_w, bs_w, rd_w;
    logic [2:0] sel = 3'd0;
    logic       mon_tx, mon_bs, mon_rd;

    int checks = 0;
    int errors = 0;

    logic tx_log [0:2399];
    logic bs_log [0:2399];
    logic rd_log [0:2399];

    always #5 clk = ~clk;

    always_comb begin
        mon_tx = tx_w[sel];
        mon_bs = bs_w[sel];
        mon_rd = rd_w[sel];
    end

    uart_tx_engine #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(data), .in_s_en(s_en[0]),
        .out_s_bs(bs_w[0]), .out_s_rd(rd_w[0]), .out_tx(tx_w[0]));
    uart_tx_engine #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(data), .in_s_en(s_en[1]),
        .out_s_bs(bs_w[1]), .out_s_rd(rd_w[1]), .out_tx(tx_w[1]));
    uart_tx_engine #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(data), .in_s_en(s_en[2]),
        .out_s_bs(bs_w[2]), .out_s_rd(rd_w[2]), .out_tx(tx_w[2]));
    uart_tx_engine #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(2)) u_dut3 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(data), .in_s_en(s_en[3]),
        .out_s_bs(bs_w[3]), .out_s_rd(rd_w[3]), .out_tx(tx_w[3]));
    uart_tx_engine #(.CLK_HZ(27_000_000), .BAUD(115200), .PARITY(0), .STOP_BITS(1)) u_dut4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(data), .in_s_en(s_en[4]),
        .out_s_bs(bs_w[4]), .out_s_rd(rd_w[4]), .out_tx(tx_w[4]));

    // ---------------- stimulus / observation helpers ----------------

    // Request a send and return just after the accepting edge.
    task automatic kick(input int idx, input logic [7:0] d);
        @(posedge clk);
        #1;
        data = d;
        s_en[idx] = 1'b1;
        @(posedge clk);
        #1;
        s_en[idx] = 1'b0;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i] = mon_tx;
            bs_log[i] = mon_bs;
            rd_log[i] = mon_rd;
        end
    endtask

    function automatic logic pick(input int which, input int i);
        case (which)
            0:       return tx_log[i];
            1:       return bs_log[i];
            default: return rd_log[i];
        endcase
    endfunction

    // 0 or 1 if the log is constant over the window, -1 otherwise.
    function automatic int seg(input int which, input int start, input int len);
        logic f;
        f = pick(which, start);
        if (f === 1'bx || f === 1'bz) return -1;
        for (int i = 1; i < len; i++) begin
            if (pick(which, start + i) !== f) return -1;
        end
        return f ? 1 : 0;
    endfunction

    // Reference receiver: mid-bit sampling from the start-bit position.
    function automatic logic [7:0] rx_byte(input int start, input int div);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k] = tx_log[start + div * (k + 1) + div / 2];
        end
        return b;
    endfunction

    function automatic int first_rd(input int from, input int n);
        for (int i = from; i < n; i++) begin
            if (rd_log[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int count_rd(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (rd_log[i] === 1'b1) c++;
        end
        return c;
    endfunction

    // ---------------- scenarios ----------------

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            sel = 3'(i);
            #1;
            checks++;
            if ({mon_tx, mon_bs, mon_rd} !== 3'b100) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got tx/bs/rd=%b expected 100", i, {mon_tx, mon_bs, mon_rd});
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: outputs checked for 5 instances");
    endtask

    task automatic test_basic();
        logic [0:7] exp_seq;
        int v;
        exp_seq = 8'b1010_1010;  // 0x55 on the wire, LSB first
        sel = 3'd0;
        kick(0, 8'h55);
        record(120);
        v = seg(0, 0, 10);
        checks++;
        if (v !== 0) begin errors++; $display("FAIL basic_start: got %0d expected 0", v); end
        for (int b = 0; b < 8; b++) begin
            v = seg(0, 10 + 10 * b, 10);
            checks++;
            if (v !== int'(exp_seq[b])) begin
                errors++;
                $display("FAIL basic_bit%0d: got %0d expected %0d", b, v, exp_seq[b]);
            end
        end
        v = seg(0, 90, 10);
        checks++;
        if (v !== 1) begin errors++; $display("FAIL basic_stop: got %0d expected 1", v); end
        v = seg(1, 0, 100);
        checks++;
        if (v !== 1 || bs_log[100] !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got window=%0d after=%b expected 1 and 0", v, bs_log[100]);
        end
        v = first_rd(0, 120);
        checks++;
        if (v !== 100 || count_rd(120) !== 1) begin
            errors++;
            $display("FAIL basic_done: got at=%0d count=%0d expected at=100 count=1", v, count_rd(120));
        end
        $display("test_basic: sent 0x55, rx=0x%02h done at %0d", rx_byte(0, 10), v);
    endtask

    task automatic test_parity();
        int v;
        // even parity, 1 stop
        sel = 3'd1;
        kick(1, 8'h07);
        record(130);
        checks++;
        if (rx_byte(0, 10) !== 8'h07) begin errors++; $display("FAIL even_data: got 0x%02h expected 0x07", rx_byte(0, 10)); end
        v = seg(0, 90, 10);
        checks++;
        if (v !== 1) begin errors++; $display("FAIL even_parity_bit: got %0d expected 1", v); end
        v = first_rd(0, 130);
        checks++;
        if (v !== 110) begin errors++; $display("FAIL even_len: got %0d expected 110", v); end
        $display("test_parity: even 0x07 parity=%b done at %0d", tx_log[95], v);
        // odd parity, 1 stop
        sel = 3'd2;
        kick(2, 8'h07);
        record(130);
        v = seg(0, 90, 10);
        checks++;
        if (v !== 0) begin errors++; $display("FAIL odd_parity_bit: got %0d expected 0", v); end
        v = first_rd(0, 130);
        checks++;
        if (v !== 110) begin errors++; $display("FAIL odd_len: got %0d expected 110", v); end
        $display("test_parity: odd 0x07 parity=%b done at %0d", tx_log[95], v);
        // even parity, 2 stop
        sel = 3'd3;
        kick(3, 8'h07);
        record(130);
        v = seg(0, 100, 20);
        checks++;
        if (v !== 1 || tx_log[95] !== 1'b1) begin
            errors++;
            $display("FAIL stop2_line: got stop=%0d parity=%b expected 1 and 1", v, tx_log[95]);
        end
        v = first_rd(0, 130);
        checks++;
        if (v !== 120) begin errors++; $display("FAIL stop2_len: got %0d expected 120", v); end
        $display("test_parity: even 2-stop 0x07 done at %0d", v);
    endtask

    task automatic test_ignored();
        int v;
        sel = 3'd0;
        kick(0, 8'hA3);
        fork
            record(130);
            begin
                repeat (40) @(posedge clk);
                #1;
                data = 8'hFF;
                s_en[0] = 1'b1;
                @(posedge clk);
                #1;
                s_en[0] = 1'b0;
            end
        join
        checks++;
        if (rx_byte(0, 10) !== 8'hA3) begin errors++; $display("FAIL ignored_data: got 0x%02h expected 0xA3", rx_byte(0, 10)); end
        v = count_rd(130);
        checks++;
        if (v !== 1 || first_rd(0, 130) !== 100) begin
            errors++;
            $display("FAIL ignored_done: got count=%0d at=%0d expected count=1 at=100", v, first_rd(0, 130));
        end
        v = seg(1, 100, 30);
        checks++;
        if (v !== 0) begin errors++; $display("FAIL ignored_idle_after: got busy=%0d expected 0", v); end
        $display("test_ignored: rx=0x%02h done pulses=%0d", rx_byte(0, 10), count_rd(130));
    endtask

    task automatic test_back_to_back();
        bit seen;
        int v;
        seen = 1'b0;
        sel = 3'd0;
        @(posedge clk);
        #1;
        data = 8'h12;
        s_en[0] = 1'b1;
        @(posedge clk);
        #1;
        fork
            record(220);
            begin
                for (int k = 0; k < 150 && !seen; k++) begin
                    @(negedge clk);
                    if (mon_rd === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    data = 8'h34;
                    @(posedge clk);
                    #1;
                end
                s_en[0] = 1'b0;
            end
        join
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_first_done: got timeout expected pulse within 150 cycles"); end
        checks++;
        if (rd_log[100] !== 1'b1 || tx_log[100] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got rd=%b tx=%b at 100 expected 1 1", rd_log[100], tx_log[100]);
        end
        v = seg(0, 101, 10);
        checks++;
        if (v !== 0) begin errors++; $display("FAIL b2b_second_start: got %0d expected 0", v); end
        checks++;
        if (rx_byte(0, 10) !== 8'h12 || rx_byte(101, 10) !== 8'h34) begin
            errors++;
            $display("FAIL b2b_data: got 0x%02h 0x%02h expected 0x12 0x34", rx_byte(0, 10), rx_byte(101, 10));
        end
        v = first_rd(101, 220);
        checks++;
        if (v !== 201 || count_rd(220) !== 2) begin
            errors++;
            $display("FAIL b2b_second_done: got at=%0d count=%0d expected at=201 count=2", v, count_rd(220));
        end
        $display("test_back_to_back: rx=0x%02h,0x%02h second done at %0d", rx_byte(0, 10), rx_byte(101, 10), v);
    endtask

    task automatic test_reset_mid();
        int v;
        sel = 3'd0;
        kick(0, 8'hC3);  // bit3 = 0, so the line is low at cycle 45
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if ({mon_tx, mon_bs} !== 2'b01) begin
            errors++;
            $display("FAIL midreset_pre: got tx/bs=%b expected 01", {mon_tx, mon_bs});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mon_tx, mon_bs, mon_rd} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_async: got tx/bs/rd=%b expected 100", {mon_tx, mon_bs, mon_rd});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        record(30);
        v = seg(0, 0, 30);
        checks++;
        if (v !== 1 || count_rd(30) !== 0 || seg(1, 0, 30) !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got tx=%0d rd=%0d busy=%0d expected 1 0 0", v, count_rd(30), seg(1, 0, 30));
        end
        kick(0, 8'h81);
        record(120);
        checks++;
        if (rx_byte(0, 10) !== 8'h81 || first_rd(0, 120) !== 100 || count_rd(120) !== 1) begin
            errors++;
            $display("FAIL midreset_resend: got 0x%02h at=%0d count=%0d expected 0x81 at=100 count=1",
                     rx_byte(0, 10), first_rd(0, 120), count_rd(120));
        end
        $display("test_reset_mid: resend rx=0x%02h done at %0d", rx_byte(0, 10), first_rd(0, 120));
    endtask

    task automatic test_default_params();
        int v;
        sel = 3'd4;
        kick(4, 8'hB5);  // bits LSB-first: 1,0,1,0,1,1,0,1
        record(2360);
        checks++;
        if (seg(0, 0, 234) !== 0 || seg(0, 234, 234) !== 1 || seg(0, 468, 234) !== 0) begin
            errors++;
            $display("FAIL default_bit_period: got start=%0d b0=%0d b1=%0d expected 0 1 0",
                     seg(0, 0, 234), seg(0, 234, 234), seg(0, 468, 234));
        end
        checks++;
        if (rx_byte(0, 234) !== 8'hB5) begin errors++; $display("FAIL default_data: got 0x%02h expected 0xB5", rx_byte(0, 234)); end
        v = first_rd(0, 2360);
        checks++;
        if (v !== 2340 || seg(0, 2106, 234) !== 1) begin
            errors++;
            $display("FAIL default_len: got at=%0d stop=%0d expected at=2340 stop=1", v, seg(0, 2106, 234));
        end
        $display("test_default_params: rx=0x%02h done at %0d", rx_byte(0, 234), v);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
